// File: rtl/pwm_i2c_pkg.sv
// Shared definitions for the I2C-addressable multi-channel PWM peripheral:
// frontend bus bit positions and the bus-side FSM encoding.
package pwm_i2c_pkg;

  // i2c_interface_rx field positions
  localparam int unsigned RX_ADDR_LSB = 0;
  localparam int unsigned RX_RW       = 7;
  localparam int unsigned RX_DATA_LSB = 8;
  localparam int unsigned RX_START    = 16;
  localparam int unsigned RX_STOP     = 17;
  localparam int unsigned RX_ADDR_STB = 18;
  localparam int unsigned RX_WR_STB   = 19;
  localparam int unsigned RX_RD_STB   = 20;

  // i2c_interface_tx field positions
  localparam int unsigned TX_ACK  = 0;
  localparam int unsigned TX_DATA = 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StPointer,
    StData,
    StRead,
    StIgnore
  } state_e;

endpackage

// File: rtl/pwm_counter_core.sv
// PWM timebase: a clock prescaler feeding a free-running WIDTH-bit counter, with a
// one-cycle pulse on the tick where the counter wraps back to zero.
module pwm_counter_core #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [WIDTH-1:0] cnt_o,
  output logic             period_wrap_o
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PreLast);
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign period_wrap_o = tick && (cnt_q == '1);

endmodule

// File: rtl/pwm_i2c_multi.sv
// Multi-channel PWM peripheral on the shared I2C frontend bus: register pointer with
// auto-increment, shadow duty registers read back over I2C, period-aligned duty updates.
module pwm_i2c_multi
  import pwm_i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR     = 7'h21,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [1:0]          i2c_interface_tx,
  input  logic [20:0]         i2c_interface_rx,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam int unsigned PtrW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(CHANNELS - 1);

  logic [6:0] rx_addr;
  logic [7:0] rx_byte;
  logic       rx_rw, start_stb, stop_stb, addr_stb, wr_stb, rd_stb;

  assign rx_addr   = i2c_interface_rx[RX_ADDR_LSB +: 7];
  assign rx_rw     = i2c_interface_rx[RX_RW];
  assign rx_byte   = i2c_interface_rx[RX_DATA_LSB +: 8];
  assign start_stb = i2c_interface_rx[RX_START];
  assign stop_stb  = i2c_interface_rx[RX_STOP];
  assign addr_stb  = i2c_interface_rx[RX_ADDR_STB];
  assign wr_stb    = i2c_interface_rx[RX_WR_STB];
  assign rd_stb    = i2c_interface_rx[RX_RD_STB];

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_next;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            ack_q, ack_d;
  logic            rd_bit_q, rd_bit_d;
  logic            wr_en;

  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];

  logic [WIDTH-1:0]    cnt;
  logic                period_wrap;
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ack_d     = 1'b0;
    rd_bit_d  = rd_bit_q;
    wr_en     = 1'b0;
    ptr_next  = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;

    // Start outranks stop so a coincident pair still opens a new transaction.
    if (start_stb) begin
      state_d = StAddr;
    end else if (stop_stb) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (addr_stb) begin
            if (rx_addr == ADDR) begin
              ack_d     = 1'b1;
              bit_cnt_d = '0;
              if (rx_rw) begin
                state_d = StRead;
                shift_d = 8'(shadow_q[ptr_q]);
              end else begin
                state_d = StPointer;
              end
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StPointer: begin
          if (wr_stb) begin
            if (32'(rx_byte) < CHANNELS) begin
              ptr_d   = PtrW'(rx_byte);
              ack_d   = 1'b1;
              state_d = StData;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StData: begin
          if (wr_stb) begin
            wr_en = 1'b1;
            ack_d = 1'b1;
            ptr_d = ptr_next;
          end
        end
        StRead: begin
          if (rd_stb) begin
            rd_bit_d  = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = ptr_next;
              shift_d = 8'(shadow_q[ptr_next]);
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end

    // Read data is only ever driven while this block owns a read transfer.
    if (state_d != StRead) rd_bit_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      rd_bit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      rd_bit_q  <= rd_bit_d;
    end
  end

  pwm_counter_core #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) u_counter (
    .clk_i        (clk),
    .rst_ni       (reset),
    .cnt_o        (cnt),
    .period_wrap_o(period_wrap)
  );

  // Active duties only change on the wrap tick, so a coincident write lands next period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      if (wr_en) shadow_q[ptr_q] <= rx_byte[WIDTH-1:0];
      if (period_wrap) begin
        for (int unsigned n = 0; n < CHANNELS; n++) active_q[n] <= shadow_q[n];
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) pwm_d[n] = (cnt < active_q[n]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end

  assign pwm_out                   = pwm_q;
  assign i2c_interface_tx[TX_ACK]  = ack_q;
  assign i2c_interface_tx[TX_DATA] = rd_bit_q;

endmodule

// File: tb/tb_pwm_i2c_multi.sv
// Self-checking bench for pwm_i2c_multi: table of write transactions, PWM duty
// measurement, read-back, period-aligned update and asynchronous reset sequences.
module tb_pwm_i2c_multi;

  localparam int unsigned Per = 512;  // 256 counter steps at PRESCALE = 2

  localparam logic [4:0] StbStart = 5'b00001;
  localparam logic [4:0] StbStop  = 5'b00010;
  localparam logic [4:0] StbAddr  = 5'b00100;
  localparam logic [4:0] StbWr    = 5'b01000;
  localparam logic [4:0] StbRd    = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] rx = '0;
  logic [1:0]  tx;
  logic [3:0]  pwm;

  int errors = 0;
  int checks = 0;
  int hi[4];
  int g[2][2];

  typedef struct {
    string name;
    int    idx;
    logic  val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] ack;  // {d1, d0, ptr, addr}
  } wr_vec_t;
  wr_vec_t vecs[4];

  always #5 clk = ~clk;

  pwm_i2c_multi #(
    .ADDR    (7'h21),
    .CHANNELS(4),
    .WIDTH   (8),
    .PRESCALE(2)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .i2c_interface_tx(tx),
    .i2c_interface_rx(rx),
    .pwm_out         (pwm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.name, 32'(tx[e.idx]), 32'(e.val));
    end
  endtask

  task automatic strobe(input logic [4:0] stb, input logic [6:0] a, input logic rw,
                        input logic [7:0] b);
    @(negedge clk);
    rx = {stb, b, rw, a};
    @(negedge clk);
    rx[20:16] = '0;
  endtask

  task automatic bus_start();
    strobe(StbStart, 7'h0, 1'b0, 8'h0);
  endtask

  task automatic bus_stop();
    strobe(StbStop, 7'h0, 1'b0, 8'h0);
  endtask

  task automatic bus_addr(input logic [6:0] a, input logic rw, input logic exp_ack);
    sb_q.push_back('{name: "addr_ack", idx: 0, val: exp_ack});
    strobe(StbAddr, a, rw, 8'h0);
    sb_pop();
  endtask

  task automatic bus_wr(input logic [7:0] b, input logic exp_ack);
    sb_q.push_back('{name: "byte_ack", idx: 0, val: exp_ack});
    strobe(StbWr, 7'h0, 1'b0, b);
    sb_pop();
  endtask

  task automatic bus_rd(input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) sb_q.push_back('{name: "rd_bit", idx: 1, val: exp[i]});
    for (int i = 0; i < 8; i++) begin
      strobe(StbRd, 7'h0, 1'b0, 8'h0);
      sb_pop();
    end
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm[c]) hi[c]++;
    end
  endtask

  // Returns on the first sample where channel ch is high after being low.
  task automatic wait_rise(input int ch, output int n);
    logic prev;
    bit   ok;
    ok   = 1'b0;
    n    = 0;
    prev = pwm[ch];
    while (!ok && n < 3 * Per) begin
      @(negedge clk);
      n++;
      if (!prev && pwm[ch]) ok = 1'b1;
      prev = pwm[ch];
    end
    check("rise_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad_pwm, bad_tx;

    vecs[0] = '{dev: 7'h21, ptr: 8'h01, d0: 8'h80, d1: 8'h40, ack: 4'b1111};
    vecs[1] = '{dev: 7'h22, ptr: 8'h00, d0: 8'hFF, d1: 8'hFF, ack: 4'b0000};
    vecs[2] = '{dev: 7'h21, ptr: 8'h07, d0: 8'hEE, d1: 8'hEE, ack: 4'b0001};
    vecs[3] = '{dev: 7'h21, ptr: 8'h03, d0: 8'h11, d1: 8'h22, ack: 4'b1111};

    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_tx", 32'(tx), 32'd0);
    rst_n = 1'b1;

    bad_pwm = 0;
    bad_tx  = 0;
    repeat (600) begin
      @(negedge clk);
      if (pwm != 4'h0) bad_pwm++;
      if (tx != 2'b00) bad_tx++;
    end
    check("idle_pwm_low", 32'(bad_pwm), 32'd0);
    check("idle_tx_low", 32'(bad_tx), 32'd0);

    for (int v = 0; v < 3; v++) begin
      bus_start();
      bus_addr(vecs[v].dev, 1'b0, vecs[v].ack[0]);
      @(negedge clk);
      check("ack_one_cycle", 32'(tx[0]), 32'd0);
      bus_wr(vecs[v].ptr, vecs[v].ack[1]);
      bus_wr(vecs[v].d0, vecs[v].ack[2]);
      bus_wr(vecs[v].d1, vecs[v].ack[3]);
      bus_stop();
      check("tx_after_stop", 32'(tx), 32'd0);
    end

    repeat (2 * Per + 10) @(negedge clk);
    measure(Per);
    check("duty_ch0", 32'(hi[0]), 32'd0);
    check("duty_ch1", 32'(hi[1]), 32'd256);
    check("duty_ch2", 32'(hi[2]), 32'd128);
    check("duty_ch3", 32'(hi[3]), 32'd0);

    wait_rise(1, n);
    wait_rise(1, n);
    check("period_clks", 32'(n), 32'(Per));

    // Pointer wrap: ptr 3 -> 0 -> 1
    bus_start();
    bus_addr(vecs[3].dev, 1'b0, vecs[3].ack[0]);
    bus_wr(vecs[3].ptr, vecs[3].ack[1]);
    bus_wr(vecs[3].d0, vecs[3].ack[2]);
    bus_wr(vecs[3].d1, vecs[3].ack[3]);
    bus_stop();

    // Read from retained pointer (1): shadow[1], shadow[2]
    bus_start();
    bus_addr(7'h21, 1'b1, 1'b1);
    bus_rd(8'h80);
    bus_rd(8'h40);
    bus_stop();

    // Pointer write, repeated start, read shadow[2] then shadow[3]
    bus_start();
    bus_addr(7'h21, 1'b0, 1'b1);
    bus_wr(8'h02, 1'b1);
    bus_start();
    bus_addr(7'h21, 1'b1, 1'b1);
    bus_rd(8'h40);
    bus_rd(8'h11);
    bus_stop();
    check("rd_bit_after_stop", 32'(tx[1]), 32'd0);

    // Read pointer wrapped to 0
    bus_start();
    bus_addr(7'h21, 1'b1, 1'b1);
    bus_rd(8'h22);
    bus_stop();

    // Mid-period rewrite: old duty must hold until the wrap
    wait_rise(1, n);
    foreach (g[p, c]) g[p][c] = 0;
    fork
      begin
        for (int p = 0; p < 2; p++) begin
          for (int k = 0; k < int'(Per); k++) begin
            if (p != 0 || k != 0) @(negedge clk);
            g[p][0] += int'(pwm[1]);
            g[p][1] += int'(pwm[2]);
          end
        end
      end
      begin
        bus_start();
        bus_addr(7'h21, 1'b0, 1'b1);
        bus_wr(8'h01, 1'b1);
        bus_wr(8'h20, 1'b1);
        bus_wr(8'hFF, 1'b1);
        bus_stop();
      end
    join
    check("glitch_old_ch1", 32'(g[0][0]), 32'd256);
    check("glitch_old_ch2", 32'(g[0][1]), 32'd128);
    check("glitch_new_ch1", 32'(g[1][0]), 32'd64);
    check("glitch_new_ch2_max", 32'(g[1][1]), 32'd510);

    // Asynchronous reset in the middle of a write
    wait_rise(1, n);
    bus_start();
    bus_addr(7'h21, 1'b0, 1'b1);
    check("pre_reset_pwm1", 32'(pwm[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm), 32'd0);
    check("async_reset_tx", 32'(tx), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_wr(8'h55, 1'b0);
    measure(Per);
    for (int c = 0; c < 4; c++) check("post_reset_duty", 32'(hi[c]), 32'd0);
    bus_start();
    bus_addr(7'h21, 1'b1, 1'b1);
    bus_rd(8'h00);
    bus_stop();

    // Coincident start and stop: start wins
    strobe(StbStart | StbStop, 7'h0, 1'b0, 8'h0);
    bus_addr(7'h21, 1'b0, 1'b1);
    bus_stop();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
